uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver: successor to the fixed 8N1 receiver.
//  Adds configurable data width, oversampling ratio and stop bits, plus 2-FF input synchroniser, false-start rejection and framing-error detection.
//  Sits between the board RX pin and the byte consumer; one-cycle o_valid pulse per received frame.
// PARAMETERS
//  DATA_BITS   8    data bits per frame, legal 5..9, sent LSB first
//  OVERSAMPLE  16   i_clk cycles per bit, even, >= 4; i_clk = OVERSAMPLE x baud
//  STOP_BITS   1    stop bits checked, 1 or 2
//  PARITY_ODD  0    0 = even parity, 1 = odd; used only with UART_RX_PARITY_EN
// PORTS
//  i_clk         in   1          receiver clock
//  i_rst_n       in   1          asynchronous active-low reset
//  i_rx          in   1          serial line, idle high, asynchronous to i_clk
//  o_data        out  DATA_BITS  last received word; held until next o_valid
//  o_valid       out  1          one-cycle pulse: o_data/o_frame_err/o_parity_err updated
//  o_frame_err   out  1          qualified by o_valid: a stop bit sampled low
//  o_parity_err  out  1          qualified by o_valid: parity mismatch (0 without macro)
//  o_busy        out  1          high from start detect until return to IDLE
// BEHAVIOUR
//  - Reset (async, i_rst_n low): o_data=0, o_valid=0, o_frame_err=0, o_parity_err=0, o_busy=0.
//    Synchroniser FFs reset to 1. State=IDLE. All counters=0. Takes effect mid-frame; partial frame is discarded, no o_valid.
//  - Synchroniser: i_rx -> 2 FFs -> rx_s. All decisions use rx_s (2-cycle input latency).
//  - Tick counter: width $clog2(OVERSAMPLE). Cleared on every state entry. Mid-bit = count OVERSAMPLE/2-1 in START, OVERSAMPLE-1 in later states.
//  - Bit index: width $clog2(DATA_BITS+1). Counts data bits.
//  - IDLE: o_busy=0. On rx_s==0 -> START, o_busy=1.
//  - START: at count OVERSAMPLE/2-1, sample rx_s.
//    1 = false start -> IDLE, no o_valid. 0 -> DATA, counter cleared (now aligned to bit centre).
//  - DATA: every OVERSAMPLE cycles, sample rx_s into shift reg (LSB first).
//    After DATA_BITS samples -> PARITY if macro defined, else STOP.
//  - PARITY (macro only): one sample; compare to XOR of data (^ PARITY_ODD) -> latch error.
//  - STOP: STOP_BITS samples, one per OVERSAMPLE cycles. Any stop sample 0 sets frame error.
//    Frame error does not abort: remaining stop samples are still taken.
//  - Completion: cycle after last stop sample, o_valid=1 for exactly one cycle.
//    o_data, o_frame_err and o_parity_err load on that same cycle. State -> IDLE.
//    IDLE is entered at mid-stop, so a start bit following immediately is caught.
//  - Frame error with line held low (break): after o_valid the receiver re-enters START.
//    It produces a further frame only if rx_s is still low at mid-bit.
//  - Latency: o_valid occurs 2 + (OVERSAMPLE/2) + OVERSAMPLE*(DATA_BITS [+1 parity] + STOP_BITS - 1) + OVERSAMPLE + 1 cycles
//    after the i_rx falling edge, within +/-1 cycle.
//  - No backpressure: the consumer must take o_data within one frame time. An unread word is overwritten.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state present, one parity bit expected between data and stop.
//    o_parity_err reports mismatch; parity uses PARITY_ODD.
//  Undefined: no parity bit in frame; o_parity_err tied 0; PARITY_ODD ignored.
// TESTING (DATA_BITS=8, OVERSAMPLE=16, STOP_BITS=1 unless noted)
//  1. Send 8N1 frame 0xA5 -> one o_valid pulse; o_data=0xA5; o_frame_err=0; o_busy low after.
//  2. i_rx low for 4 cycles then high -> false start: no o_valid; o_busy returns 0 within 12 cycles.
//  3. Frame 0x3C with stop bit forced 0 -> o_valid with o_data=0x3C, o_frame_err=1.
//  4. Back-to-back 0x00 then 0xFF, no idle gap -> two o_valid pulses, data 0x00 then 0xFF, no errors.
//  5. Assert i_rst_n low during data bit 4, release, send 0x81 -> no o_valid for the aborted frame.
//     Then exactly one o_valid with o_data=0x81.
//  6. UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 0 -> o_parity_err=1; with parity bit 1 -> 0.
//     STOP_BITS=2: second stop bit 0 -> o_frame_err=1.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (2-FF synchroniser, false-start rejection,
// framing check). Define UART_RX_PARITY_EN to expect one parity bit between data and stop.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] TICK_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] TICK_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 rx_meta_q, rx_s_q;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q + 1'b1;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    ferr_d      = ferr_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
    perr_d       = perr_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        stop_d = 1'b0;
        ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d = 1'b0;
`endif
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // Half-bit wait re-centres all later samples on the bit middle.
        if (tick_q == TICK_HALF) begin
          tick_d  = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_q == TICK_FULL) begin
          tick_d  = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick_q == TICK_FULL) begin
          tick_d  = '0;
          perr_d  = rx_s_q != (^shift_q ^ PARITY_ODD[0]);
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick_q == TICK_FULL) begin
          tick_d = '0;
          // A low stop bit is recorded but the remaining stop samples are still taken.
          ferr_d = ferr_q | ~rx_s_q;
          if (stop_q == STOP_LAST) begin
            valid_d     = 1'b1;
            data_d      = shift_q;
            frame_err_d = ferr_q | ~rx_s_q;
`ifdef UART_RX_PARITY_EN
            parity_err_d = perr_q;
`endif
            state_d = S_IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      ferr_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= i_rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      ferr_q      <= ferr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`else
  // No parity bit in the frame, so PARITY_ODD has no effect here.
  assign o_parity_err = 1'b0 & PARITY_ODD[0];
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed cases plus random frames against a frame-level model.
module tb_uart_rx_param;
  localparam int OS   = 16;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx1 = 1'b1, rx2 = 1'b1;
  logic [7:0] d1, d2;
  logic v1, v2, fe1, fe2, pe1, pe2, b1, b2;

  int checks = 0, errors = 0;
  int cyc = 0;
  int pulses1 = 0, pulses2 = 0, dbl = 0, last_v1_cyc = 0;
  int sent1 = 0, sent2 = 0;
  logic v1p = 1'b0, v2p = 1'b0;
  logic [7:0] qd1[$], qd2[$];
  logic qf1[$], qf2[$], qp1[$], qp2[$];

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_ODD(PODD)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx1), .o_data(d1), .o_valid(v1),
    .o_frame_err(fe1), .o_parity_err(pe1), .o_busy(b1));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(2), .PARITY_ODD(PODD)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx2), .o_data(d2), .o_valid(v2),
    .o_frame_err(fe2), .o_parity_err(pe2), .o_busy(b2));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    v1p <= v1;
    v2p <= v2;
    if (v1) begin
      qd1.push_back(d1); qf1.push_back(fe1); qp1.push_back(pe1);
      pulses1 <= pulses1 + 1;
      last_v1_cyc <= cyc;
      if (v1p) dbl <= dbl + 1;
    end
    if (v2) begin
      qd2.push_back(d2); qf2.push_back(fe2); qp2.push_back(pe2);
      pulses2 <= pulses2 + 1;
      if (v2p) dbl <= dbl + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_pe(input logic [7:0] d, input logic par);
    logic want;
    want = (^d) ^ PODD[0];
    return (PB == 1) ? (par != want) : 1'b0;
  endfunction

  task automatic drive(input bit which, input logic b, input int n);
    if (which) rx2 = b; else rx1 = b;
    repeat (n) @(negedge clk);
  endtask

  // start, 8 data LSB first, optional parity, 1 stop (dut1) or 2 stops (dut2)
  task automatic send(input bit which, input logic [7:0] d, input logic par,
                      input logic s1, input logic s2);
    logic [15:0] fb;
    int n;
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = d[i];
    n = 9;
    if (PB == 1) begin fb[n] = par; n++; end
    fb[n] = s1; n++;
    if (which) begin fb[n] = s2; n++; end
    for (int i = 0; i < n; i++) drive(which, fb[i], OS);
    if (which) rx2 = 1'b1; else rx1 = 1'b1;
    if (which) sent2++; else sent1++;
  endtask

  task automatic expect_frame(input bit which, input logic [7:0] d, input logic fe,
                              input logic pe, input string tag);
    int w, have;
    logic [7:0] gd;
    logic gf, gp;
    w = 0;
    have = which ? qd2.size() : qd1.size();
    while (have == 0 && w < 64) begin
      @(negedge clk);
      w++;
      have = which ? qd2.size() : qd1.size();
    end
    chk({tag, "_arrived"}, (have != 0), 1);
    if (have != 0) begin
      if (which) begin gd = qd2.pop_front(); gf = qf2.pop_front(); gp = qp2.pop_front(); end
      else       begin gd = qd1.pop_front(); gf = qf1.pop_front(); gp = qp1.pop_front(); end
      chk({tag, "_data"}, gd, d);
      chk({tag, "_ferr"}, gf, fe);
      chk({tag, "_perr"}, gp, pe);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic par, s1, s2;
    bit which;
    int t0, lat, lat_exp, w, p0, gap;

    repeat (3) @(negedge clk);
    chk("rst_data", d1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_ferr", fe1, 0);
    chk("rst_perr", pe1, 0);
    chk("rst_busy", b1, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: plain frame, latency, idle afterwards
    t0 = cyc;
    send(0, 8'hA5, (^8'hA5) ^ PODD[0], 1'b1, 1'b0);
    expect_frame(0, 8'hA5, 1'b0, 1'b0, "t1");
    lat_exp = 2 + OS / 2 + OS * (8 + PB + 1 - 1) + OS + 1;
    lat = last_v1_cyc - t0;
    if (lat >= lat_exp - 1 && lat <= lat_exp + 1) lat = lat_exp;
    chk("t1_latency", lat, lat_exp);
    chk("t1_busy_after", b1, 0);

    // 2: glitch shorter than half a bit
    p0 = pulses1;
    drive(0, 1'b0, 4);
    chk("t2_busy_seen", b1, 1);
    rx1 = 1'b1;
    w = 0;
    while (b1 !== 1'b0 && w < 12) begin @(negedge clk); w++; end
    chk("t2_busy_drop", b1, 0);
    repeat (40) @(negedge clk);
    chk("t2_no_valid", pulses1 - p0, 0);

    // 3: low stop bit
    send(0, 8'h3C, (^8'h3C) ^ PODD[0], 1'b0, 1'b0);
    expect_frame(0, 8'h3C, 1'b1, 1'b0, "t3");
    repeat (OS) @(negedge clk);

    // 4: back-to-back frames
    send(0, 8'h00, PODD[0], 1'b1, 1'b0);
    send(0, 8'hFF, PODD[0], 1'b1, 1'b0);
    expect_frame(0, 8'h00, 1'b0, 1'b0, "t4a");
    expect_frame(0, 8'hFF, 1'b0, 1'b0, "t4b");
    repeat (OS) @(negedge clk);

    // 5: reset during data bit 4
    d = 8'h5A;
    drive(0, 1'b0, OS);
    for (int i = 0; i < 4; i++) drive(0, d[i], OS);
    drive(0, d[4], OS / 2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", b1, 0);
    chk("t5_rst_data", d1, 0);
    chk("t5_rst_valid", v1, 0);
    @(negedge clk);
    rx1 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("t5_aborted_none", qd1.size(), 0);
    send(0, 8'h81, (^8'h81) ^ PODD[0], 1'b1, 1'b0);
    sent1--;  // aborted frame above was never counted; keep totals consistent
    sent1++;
    expect_frame(0, 8'h81, 1'b0, 1'b0, "t5");
    repeat (20) @(negedge clk);
    chk("t5_exactly_one", qd1.size(), 0);

    // 6: two stop bits
    send(1, 8'h96, (^8'h96) ^ PODD[0], 1'b1, 1'b1);
    expect_frame(1, 8'h96, 1'b0, 1'b0, "t6_ok");
    send(1, 8'h4B, (^8'h4B) ^ PODD[0], 1'b1, 1'b0);
    expect_frame(1, 8'h4B, 1'b1, 1'b0, "t6_stop2_low");
    repeat (OS) @(negedge clk);
    send(1, 8'hC3, (^8'hC3) ^ PODD[0], 1'b0, 1'b1);
    expect_frame(1, 8'hC3, 1'b1, 1'b0, "t6_stop1_low");
    repeat (OS) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    send(0, 8'h07, 1'b0, 1'b1, 1'b0);
    expect_frame(0, 8'h07, 1'b0, 1'b1, "t6_par_bad");
    send(0, 8'h07, 1'b1, 1'b1, 1'b0);
    expect_frame(0, 8'h07, 1'b0, 1'b0, "t6_par_good");
`endif

    // random frames on both receivers
    for (int k = 0; k < 40; k++) begin
      which = 1'($urandom_range(0, 1));
      d     = 8'($urandom);
      par   = 1'($urandom_range(0, 1));
      s1    = ($urandom_range(0, 3) != 0);
      s2    = ($urandom_range(0, 3) != 0);
      send(which, d, par, s1, s2);
      expect_frame(which, d, which ? ~(s1 & s2) : ~s1, exp_pe(d, par), "rnd");
      gap = ((which ? s2 : s1) == 1'b0) ? OS + $urandom_range(0, 7) : $urandom_range(0, 19);
      repeat (gap) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    chk("end_no_double_pulse", dbl, 0);
    chk("end_pulses1", pulses1, sent1);
    chk("end_pulses2", pulses2, sent2);
    chk("end_q1_empty", qd1.size(), 0);
    chk("end_q2_empty", qd2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
